pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock (all state updates on rising edge).
REQ-002 SHALL have: nRST  in  1  synchronous active-low reset, sampled on rising CLK.
REQ-003 SHALL have: ihit  in  1  instruction fetch complete this cycle.
REQ-004 SHALL have: dhit  in  1  data access in MEM stage complete this cycle.
REQ-005 SHALL have: mem_dreq  in  1  MEM-stage instruction issues dREN or dWEN.
REQ-006 SHALL have: hazard  in  1  load-use hazard on ID-stage instruction, from hazard unit.
REQ-007 SHALL have: redirect  in  1  branch taken or jump resolved in ID (hazard unit branch|jump).
REQ-008 SHALL have: mem_halt  in  1  HALT opcode in MEM stage.
REQ-009 SHALL have: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables for PC and pipeline latches.
REQ-010 SHALL have: ifid_flush, idex_flush  out  1 each  latch loads bubble (all-zero) next edge.
REQ-011 SHALL have: halt  out  1  processor halted, sticky until reset.
REQ-012 With PIPE_PERF_EN: cycle_cnt, stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN, HALTING, HALTED; all outputs except counters combinational from state and inputs.
REQ-014 SHALL never assert a latch's en and flush in the same cycle; flush implies zero-load regardless of en.
REQ-015 In RUN, priority (highest first): dmem stall, halt, load-use, redirect, imiss, normal.
REQ-016 Dmem stall (mem_dreq=1, dhit=0): all enables 0, no flush; FSM stays RUN.
REQ-017 Halt (mem_halt=1, not dmem stall): pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1; next state HALTING.
REQ-018 Load-use (hazard=1): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
REQ-019 Redirect with ihit=1: pc_en=1 (target loaded), ifid_flush=1, idex_en=exmem_en=memwb_en=1.
REQ-020 Redirect with ihit=0: pc_en=0, ifid_en=0, idex_flush=1, rest enabled; redirect retried next cycle.
REQ-021 Imiss (ihit=0, no higher event): pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
REQ-022 Normal (ihit=1, no event): all enables 1, no flush.
REQ-023 HALTING: all enables 0 and flushes 0 for exactly one cycle, then HALTED unconditionally.
REQ-024 HALTED: all enables and flushes 0, halt=1; inputs ignored until reset.
REQ-025 mem_dreq with dhit=1 in the same cycle SHALL be treated as no dmem stall.

Reset
REQ-026 nRST=0 at a rising edge SHALL force state RUN and, if compiled, all counters to 0, from any state including mid-stall or HALTED.
REQ-027 While nRST=0, outputs SHALL reflect state RUN evaluated on current inputs; halt=0.

Configuration
REQ-028 Macro PIPE_PERF_EN defined: cycle_cnt increments every non-HALTED cycle; stall_cnt increments when state=RUN and pc_en=0; flush_cnt increments when ifid_flush or idex_flush is 1; all wrap at 2^32; frozen in HALTED.
REQ-029 PIPE_PERF_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 pipe_state_t enum (RUN, HALTING, HALTED) and word_t SHALL live in cpu_types_pkg.
REQ-031 Counters SHALL be one sub-module pipe_perf_counters, instantiated only under PIPE_PERF_EN.
REQ-032 Interface signals SHALL be bundled in pipeline_ctrl_if with modports ctrl and tb.

Verification
REQ-033 Reset then ihit=1, no events for 5 cycles -> all enables 1, no flush, halt=0; cycle_cnt=5.
REQ-034 mem_dreq=1, dhit=0 for 3 cycles then dhit=1 -> all enables 0 for 3 cycles, all 1 on 4th; stall_cnt=3.
REQ-035 hazard=1 and redirect=1 together, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; flush_cnt +1.
REQ-036 redirect=1 with ihit=0 for 2 cycles then ihit=1 -> idex_flush=1 twice, then pc_en=1, ifid_flush=1.
REQ-037 mem_halt=1 -> memwb_en=1 only, next cycle HALTING all 0, then halt=1 held 10 cycles with counters frozen; nRST=0 one edge -> halt=0, counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: state encoding, data word and the bundle of
// latch enables/flushes produced by pipeline_ctrl.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTING = 2'd1,
      HALTED  = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_HOLD    = '0;
   localparam pipe_ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                           exmem_en: 1'b1, memwb_en: 1'b1,
                                           ifid_flush: 1'b0, idex_flush: 1'b0};

   // Inserts a bubble into ID/EX while freezing PC and IF/ID; used for
   // load-use stalls and for a redirect that has no fetched target yet.
   function automatic pipe_ctrl_t bubble_idex();
      pipe_ctrl_t c;
      c            = CTRL_HOLD;
      c.idex_flush = 1'b1;
      c.exmem_en   = 1'b1;
      c.memwb_en   = 1'b1;
      return c;
   endfunction

   // Inserts a bubble into IF/ID; pc_en selects whether a new PC is taken.
   function automatic pipe_ctrl_t bubble_ifid(input logic load_pc);
      pipe_ctrl_t c;
      c            = CTRL_ADVANCE;
      c.pc_en      = load_pc;
      c.ifid_en    = 1'b0;
      c.ifid_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle around pipeline_ctrl; counter signals exist only when
// PIPE_PERF_EN is defined.
interface pipeline_ctrl_if (
   input logic CLK
);
   logic nRST;
   logic ihit;
   logic dhit;
   logic mem_dreq;
   logic hazard;
   logic redirect;
   logic mem_halt;
   logic pc_en;
   logic ifid_en;
   logic idex_en;
   logic exmem_en;
   logic memwb_en;
   logic ifid_flush;
   logic idex_flush;
   logic halt;
`ifdef PIPE_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   modport ctrl (
      input  CLK, nRST, ihit, dhit, mem_dreq, hazard, redirect, mem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt
`ifdef PIPE_PERF_EN
      , output cycle_cnt, stall_cnt, flush_cnt
`endif
   );

   modport tb (
      input  CLK,
      output nRST, ihit, dhit, mem_dreq, hazard, redirect, mem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt
`ifdef PIPE_PERF_EN
      , input cycle_cnt, stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/pipe_perf_counters.sv
// Pipeline performance counters (cycles, stalls, flushes); the whole module
// exists only when PIPE_PERF_EN is defined.
`ifdef PIPE_PERF_EN
module pipe_perf_counters
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        cnt_en,
   input  logic        stall_inc,
   input  logic        flush_inc,
   output logic [31:0] cycle_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   word_t cycle_q, stall_q, flush_q;

   // Counters wrap naturally at 2^32; cnt_en low freezes all three.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cycle_q <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else if (cnt_en) begin
         cycle_q <= cycle_q + 32'd1;
         if (stall_inc) stall_q <= stall_q + 32'd1;
         if (flush_inc) flush_q <= flush_q + 32'd1;
      end
   end

   assign cycle_cnt = cycle_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller for the 5-stage datapath.
// Optional performance counters are compiled in with PIPE_PERF_EN.
//
// state   | meaning
// RUN     | normal operation, stall/flush priority resolved each cycle
// HALTING | HALT retired through MEM/WB, pipeline frozen for one cycle
// HALTED  | everything frozen, halt=1 until reset
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        mem_dreq,
   input  logic        hazard,
   input  logic        redirect,
   input  logic        mem_halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        halt
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   pipe_state_t state, state_nxt, state_eff;
   pipe_ctrl_t  ctrl;
   logic        dmem_stall;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= RUN;
      else       state <= state_nxt;
   end

   // Reset is synchronous, so outputs during reset must already look like RUN.
   assign state_eff  = nRST ? state : RUN;
   assign dmem_stall = mem_dreq && !dhit;

   always_comb begin
      ctrl      = CTRL_HOLD;
      state_nxt = state_eff;
      halt      = 1'b0;
      unique case (state_eff)
         RUN: begin
            if (dmem_stall) begin
               ctrl = CTRL_HOLD;
            end else if (mem_halt) begin
               ctrl.memwb_en = 1'b1;
               state_nxt     = HALTING;
            end else if (hazard || (redirect && !ihit)) begin
               ctrl = bubble_idex();
            end else if (redirect) begin
               ctrl = bubble_ifid(1'b1);
            end else if (!ihit) begin
               ctrl = bubble_ifid(1'b0);
            end else begin
               ctrl = CTRL_ADVANCE;
            end
         end
         HALTING: state_nxt = HALTED;
         HALTED:  halt      = 1'b1;
         default: state_nxt = RUN;
      endcase
   end

   assign pc_en      = ctrl.pc_en;
   assign ifid_en    = ctrl.ifid_en;
   assign idex_en    = ctrl.idex_en;
   assign exmem_en   = ctrl.exmem_en;
   assign memwb_en   = ctrl.memwb_en;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_flush = ctrl.idex_flush;

`ifdef PIPE_PERF_EN
   pipe_perf_counters u_perf (
      .CLK       (CLK),
      .nRST      (nRST),
      .cnt_en    (state_eff != HALTED),
      .stall_inc ((state_eff == RUN) && !ctrl.pc_en),
      .flush_inc (ctrl.ifid_flush || ctrl.idex_flush),
      .cycle_cnt (cycle_cnt),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`endif

endmodule
